// File: rtl/facelet_pkg.sv
// ---------------------------------------------------------------------------
// facelet_pkg
//   Shared types and helpers for the cube-face colour capture block.
//   - scan_state_t : capture sequencer states (IDLE, ARM, ACCUM)
//   - rgb_t        : packed 8-bit-per-channel colour
//   - FACELETS     : number of facelets on one cube face (3x3 grid)
//   - idx_col/row  : grid column / row of a facelet index (row-major order)
// ---------------------------------------------------------------------------
package facelet_pkg;

    localparam int FACELETS = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        ACCUM = 2'd2
    } scan_state_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // Grid column of a facelet; out-of-range indices fold onto column 0.
    function automatic logic [1:0] idx_col(input logic [3:0] idx);
        logic [1:0] col;
        case (idx)
            4'd0, 4'd3, 4'd6: col = 2'd0;
            4'd1, 4'd4, 4'd7: col = 2'd1;
            4'd2, 4'd5, 4'd8: col = 2'd2;
            default:          col = 2'd0;
        endcase
        return col;
    endfunction

    // Grid row of a facelet; out-of-range indices fold onto row 0.
    function automatic logic [1:0] idx_row(input logic [3:0] idx);
        logic [1:0] row;
        case (idx)
            4'd0, 4'd1, 4'd2: row = 2'd0;
            4'd3, 4'd4, 4'd5: row = 2'd1;
            4'd6, 4'd7, 4'd8: row = 2'd2;
            default:          row = 2'd0;
        endcase
        return row;
    endfunction

endpackage

// File: rtl/window_accum.sv
// ---------------------------------------------------------------------------
// window_accum
//   Three-channel box accumulator for one sampling window. Sums the colour
//   of every enabled pixel, counts them (saturating), and presents the
//   average as the sum shifted right by 2*LOG2_WIN (truncating).
// Ports
//   Clk, Reset : clock, asynchronous active-high reset
//   clr        : clear sums and count (wins over en)
//   en         : add pix into the sums and bump the count
//   pix        : colour of the current pixel
//   avg        : sum >> 2*LOG2_WIN per channel
//   count      : number of pixels accumulated since the last clear
// ---------------------------------------------------------------------------
module window_accum
    import facelet_pkg::*;
#(
    parameter int LOG2_WIN = 4
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  clr,
    input  logic                  en,
    input  rgb_t                  pix,
    output rgb_t                  avg,
    output logic [2*LOG2_WIN:0]   count
);

    localparam int SH = 2 * LOG2_WIN;
    localparam int AW = 8 + SH;
    localparam int CW = SH + 1;
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    logic [AW-1:0] r_acc_r;
    logic [AW-1:0] r_acc_g;
    logic [AW-1:0] r_acc_b;
    logic [CW-1:0] r_count;

    // Sum the enabled pixels per channel and count them, saturating the count.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_acc_r <= {AW{1'b0}};
            r_acc_g <= {AW{1'b0}};
            r_acc_b <= {AW{1'b0}};
            r_count <= {CW{1'b0}};
        end else if (clr) begin
            r_acc_r <= {AW{1'b0}};
            r_acc_g <= {AW{1'b0}};
            r_acc_b <= {AW{1'b0}};
            r_count <= {CW{1'b0}};
        end else if (en) begin
            r_acc_r <= r_acc_r + AW'(pix.r);
            r_acc_g <= r_acc_g + AW'(pix.g);
            r_acc_b <= r_acc_b + AW'(pix.b);
            if (r_count != CNT_MAX) begin
                r_count <= r_count + CW'(1);
            end
        end
    end

    // Dividing by WIN*WIN is just dropping the low SH bits of each sum.
    assign avg.r = r_acc_r[AW-1:SH];
    assign avg.g = r_acc_g[AW-1:SH];
    assign avg.b = r_acc_b[AW-1:SH];
    assign count = r_count;

endmodule

// File: rtl/facelet_scan_ctrl.sv
// ---------------------------------------------------------------------------
// facelet_scan_ctrl
//   Steps a WIN x WIN sampling window over the 3x3 facelet grid, one facelet
//   per video frame, box-averages the camera colour inside it and stores the
//   nine averages. Also drives the overlay (CubeX/CubeY/CubeS/Color_*) so the
//   colour mapper can highlight the facelet being sampled.
// Ports
//   Clk, Reset          : clock, asynchronous active-high reset
//   start               : pulse, begins a 9-facelet scan (ignored while busy)
//   frame_start         : pulse at the start of each video frame
//   pix_valid           : DrawX/DrawY/pix_* describe a valid pixel
//   DrawX, DrawY        : pixel coordinates
//   pix_R/G/B           : camera colour of the pixel
//   rd_idx, rd_R/G/B    : combinational read port into the facelet store
//   CubeX, CubeY, CubeS : active facelet centre and half window size
//   Color_R/G/B         : last stored average
//   cur_idx             : facelet being sampled
//   busy, done, err     : scan in progress / scan finished pulse /
//                         some window of this scan was short of pixels
// ---------------------------------------------------------------------------
module facelet_scan_ctrl
    import facelet_pkg::*;
#(
    parameter int X0       = 280,
    parameter int Y0       = 200,
    parameter int PITCH    = 40,
    parameter int LOG2_WIN = 4
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       start,
    input  logic       frame_start,
    input  logic       pix_valid,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic [7:0] pix_R,
    input  logic [7:0] pix_G,
    input  logic [7:0] pix_B,
    input  logic [3:0] rd_idx,
    output logic [7:0] rd_R,
    output logic [7:0] rd_G,
    output logic [7:0] rd_B,
    output logic [9:0] CubeX,
    output logic [9:0] CubeY,
    output logic [9:0] CubeS,
    output logic [7:0] Color_R,
    output logic [7:0] Color_G,
    output logic [7:0] Color_B,
    output logic [3:0] cur_idx,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int WIN  = 1 << LOG2_WIN;
    localparam int HALF = WIN / 2;
    localparam int CW   = 2 * LOG2_WIN + 1;

    localparam logic [1:0] S_IDLE  = 2'(IDLE);
    localparam logic [1:0] S_ARM   = 2'(ARM);
    localparam logic [1:0] S_ACCUM = 2'(ACCUM);

    localparam logic signed [10:0] HALF_S   = 11'(HALF);
    localparam logic [CW-1:0]      FULL_CNT = CW'(WIN * WIN);
    localparam logic [3:0]         LAST_IDX = 4'(FACELETS - 1);

    logic [1:0]  r_state;
    logic [3:0]  r_cur_idx;
    logic [9:0]  r_cx;
    logic [9:0]  r_cy;
    rgb_t        r_color;
    rgb_t        r_store [FACELETS];
    logic        r_busy;
    logic        r_done;
    logic        r_err;

    logic signed [10:0] w_dx;
    logic signed [10:0] w_dy;
    logic               w_inside;
    logic               w_store_ev;
    logic               w_acc_clr;
    logic               w_acc_en;
    rgb_t               w_pix;
    rgb_t               w_avg;
    rgb_t               w_rd;
    logic [CW-1:0]      w_count;

    function automatic logic [9:0] centre_x(input logic [3:0] idx);
        return 10'(X0 + PITCH * int'(idx_col(idx)));
    endfunction

    function automatic logic [9:0] centre_y(input logic [3:0] idx);
        return 10'(Y0 + PITCH * int'(idx_row(idx)));
    endfunction

    // Offsets are taken in 11-bit signed so windows near the screen edges
    // never wrap around and catch pixels from the opposite side.
    assign w_dx = $signed({1'b0, DrawX}) - $signed({1'b0, r_cx});
    assign w_dy = $signed({1'b0, DrawY}) - $signed({1'b0, r_cy});
    assign w_inside = (w_dx >= -HALF_S) && (w_dx <= (HALF_S - 11'sd1)) &&
                      (w_dy >= -HALF_S) && (w_dy <= (HALF_S - 11'sd1));

    // A frame boundary closes the current window; any pixel that arrives
    // with it belongs to neither window and is dropped.
    assign w_store_ev = (r_state == S_ACCUM) && frame_start;
    assign w_acc_clr  = ((r_state == S_ARM) && frame_start) || w_store_ev;
    assign w_acc_en   = (r_state == S_ACCUM) && pix_valid && w_inside && !frame_start;

    assign w_pix.r = pix_R;
    assign w_pix.g = pix_G;
    assign w_pix.b = pix_B;

    window_accum #(
        .LOG2_WIN (LOG2_WIN)
    ) u_accum (
        .Clk   (Clk),
        .Reset (Reset),
        .clr   (w_acc_clr),
        .en    (w_acc_en),
        .pix   (w_pix),
        .avg   (w_avg),
        .count (w_count)
    );

    // Scan sequencer: facelet index, window centre, overlay colour and status.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state   <= S_IDLE;
            r_cur_idx <= 4'd0;
            r_cx      <= centre_x(4'd0);
            r_cy      <= centre_y(4'd0);
            r_color   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state   <= S_ARM;
                        r_busy    <= 1'b1;
                        r_err     <= 1'b0;
                        r_cur_idx <= 4'd0;
                        r_cx      <= centre_x(4'd0);
                        r_cy      <= centre_y(4'd0);
                    end
                end
                S_ARM: begin
                    if (frame_start) begin
                        r_state <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (frame_start) begin
                        r_color <= w_avg;
                        r_err   <= r_err | (w_count != FULL_CNT);
                        if (r_cur_idx == LAST_IDX) begin
                            // cur_idx and the centre stay on the last facelet
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_cur_idx <= r_cur_idx + 4'd1;
                            r_cx      <= centre_x(r_cur_idx + 4'd1);
                            r_cy      <= centre_y(r_cur_idx + 4'd1);
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Facelet store: written with the window average as each frame closes.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < FACELETS; i++) begin
                r_store[i] <= '0;
            end
        end else if (w_store_ev && (r_cur_idx <= LAST_IDX)) begin
            r_store[r_cur_idx] <= w_avg;
        end
    end

    // Read port: out-of-range addresses read as black.
    always_comb begin
        w_rd = '0;
        if (rd_idx <= LAST_IDX) begin
            w_rd = r_store[rd_idx];
        end else begin
            w_rd = '0;
        end
    end

    assign rd_R    = w_rd.r;
    assign rd_G    = w_rd.g;
    assign rd_B    = w_rd.b;
    assign CubeX   = r_cx;
    assign CubeY   = r_cy;
    assign CubeS   = 10'(HALF);
    assign Color_R = r_color.r;
    assign Color_G = r_color.g;
    assign Color_B = r_color.b;
    assign cur_idx = r_cur_idx;
    assign busy    = r_busy;
    assign done    = r_done;
    assign err     = r_err;

endmodule

// File: tb/tb_facelet_scan_ctrl.sv
// Bench for facelet_scan_ctrl: two instances (normal grid and a grid pushed
// off the right screen edge) share one pixel stream and are compared every
// cycle against a frame-counting reference model.
module tb_facelet_scan_ctrl;

    localparam int MODE_CONST = 1;
    localparam int MODE_ALT   = 2;
    localparam int MODE_RAND  = 3;
    localparam int MODE_START = 5;
    localparam int MODE_EDGE  = 6;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       start;
    logic       frame_start;
    logic       pix_valid;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic [7:0] pix_R;
    logic [7:0] pix_G;
    logic [7:0] pix_B;
    logic [3:0] rd_idx;

    logic [7:0] a_rd_R, a_rd_G, a_rd_B, a_col_R, a_col_G, a_col_B;
    logic [9:0] a_cx, a_cy, a_cs;
    logic [3:0] a_cur;
    logic       a_busy, a_done, a_err;
    logic [7:0] b_rd_R, b_rd_G, b_rd_B, b_col_R, b_col_G, b_col_B;
    logic [9:0] b_cx, b_cy, b_cs;
    logic [3:0] b_cur;
    logic       b_busy, b_done, b_err;

    facelet_scan_ctrl #(.X0(280), .Y0(200), .PITCH(40), .LOG2_WIN(4)) u_dut (
        .Clk(Clk), .Reset(Reset), .start(start), .frame_start(frame_start),
        .pix_valid(pix_valid), .DrawX(DrawX), .DrawY(DrawY),
        .pix_R(pix_R), .pix_G(pix_G), .pix_B(pix_B), .rd_idx(rd_idx),
        .rd_R(a_rd_R), .rd_G(a_rd_G), .rd_B(a_rd_B),
        .CubeX(a_cx), .CubeY(a_cy), .CubeS(a_cs),
        .Color_R(a_col_R), .Color_G(a_col_G), .Color_B(a_col_B),
        .cur_idx(a_cur), .busy(a_busy), .done(a_done), .err(a_err));

    facelet_scan_ctrl #(.X0(630), .Y0(200), .PITCH(40), .LOG2_WIN(4)) u_dut_edge (
        .Clk(Clk), .Reset(Reset), .start(start), .frame_start(frame_start),
        .pix_valid(pix_valid), .DrawX(DrawX), .DrawY(DrawY),
        .pix_R(pix_R), .pix_G(pix_G), .pix_B(pix_B), .rd_idx(rd_idx),
        .rd_R(b_rd_R), .rd_G(b_rd_G), .rd_B(b_rd_B),
        .CubeX(b_cx), .CubeY(b_cy), .CubeS(b_cs),
        .Color_R(b_col_R), .Color_G(b_col_G), .Color_B(b_col_B),
        .cur_idx(b_cur), .busy(b_busy), .done(b_done), .err(b_err));

    always #10 Clk = ~Clk;

    // ---------------- reference model ----------------
    // m_fc counts frame_starts since an accepted start (-1 = no scan running);
    // pixels seen after the k-th frame_start belong to facelet k-1.
    int          x0s [2] = '{280, 630};
    int          m_fc;
    int          m_cur;
    int          m_sum [2][3];
    int          m_cnt [2];
    logic [23:0] m_store [2][9];
    logic [23:0] m_color [2];
    bit          m_err [2];
    bit          m_done;
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_done   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            if (n_errors <= 30)
                $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int cen_x(int d, int idx);
        return x0s[d] + (idx % 3) * 40;
    endfunction

    function automatic int cen_y(int idx);
        return 200 + (idx / 3) * 40;
    endfunction

    function automatic bit in_win(int d, int idx, int x, int y);
        return (x >= cen_x(d, idx) - 8) && (x <= cen_x(d, idx) + 7) &&
               (y >= cen_y(idx) - 8)    && (y <= cen_y(idx) + 7);
    endfunction

    function automatic logic [23:0] pix_col(int mode, int x);
        case (mode)
            MODE_CONST: return 24'h4080C0;
            MODE_ALT:   return (x % 2 == 1) ? 24'hFFFFFF : 24'h000000;
            MODE_EDGE:  return 24'h102030;
            default:    return 24'($urandom);
        endcase
    endfunction

    task automatic clear_sums();
        for (int d = 0; d < 2; d++) begin
            m_cnt[d] = 0;
            for (int c = 0; c < 3; c++) m_sum[d][c] = 0;
        end
    endtask

    task automatic model_reset();
        m_fc = -1; m_cur = 0; m_done = 0;
        clear_sums();
        for (int d = 0; d < 2; d++) begin
            m_color[d] = 24'h0; m_err[d] = 0;
            for (int i = 0; i < 9; i++) m_store[d][i] = 24'h0;
        end
    endtask

    task automatic model_step(input bit st, input bit fs, input bit pv,
                              input int x, input int y, input logic [23:0] c);
        bit was_idle;
        logic [23:0] avg;
        was_idle = (m_fc == -1);
        m_done = 0;
        if (fs) begin
            if (m_fc >= 1 && m_fc <= 9) begin
                for (int d = 0; d < 2; d++) begin
                    avg = {8'(m_sum[d][0] / 256), 8'(m_sum[d][1] / 256), 8'(m_sum[d][2] / 256)};
                    m_store[d][m_fc-1] = avg;
                    m_color[d] = avg;
                    if (m_cnt[d] != 256) m_err[d] = 1;
                end
                clear_sums();
                if (m_fc == 9) begin
                    m_fc = -1; m_done = 1;
                end else begin
                    m_fc++; m_cur = m_fc - 1;
                end
            end else if (m_fc == 0) begin
                m_fc = 1; m_cur = 0; clear_sums();
            end
        end else if (pv && m_fc >= 1 && m_fc <= 9) begin
            for (int d = 0; d < 2; d++) begin
                if (in_win(d, m_cur, x, y)) begin
                    m_sum[d][0] += int'(c[23:16]);
                    m_sum[d][1] += int'(c[15:8]);
                    m_sum[d][2] += int'(c[7:0]);
                    m_cnt[d]++;
                end
            end
        end
        if (st && was_idle) begin
            m_fc = 0; m_cur = 0; m_err[0] = 0; m_err[1] = 0;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic drive(input bit st, input bit fs, input bit pv,
                         input int x, input int y, input logic [23:0] c);
        start = st; frame_start = fs; pix_valid = pv;
        DrawX = 10'(x); DrawY = 10'(y);
        {pix_R, pix_G, pix_B} = c;
        @(posedge Clk); #1;
        model_step(st, fs, pv, x, y, c);
        n_done += int'(a_done);
        check("done", 32'(a_done), 32'(m_done));
        check("done_edge", 32'(b_done), 32'(m_done));
        check("busy", 32'(a_busy), 32'(m_fc != -1));
        check("busy_edge", 32'(b_busy), 32'(m_fc != -1));
        check("cur_idx", 32'(a_cur), 32'(m_cur));
        check("cur_idx_edge", 32'(b_cur), 32'(m_cur));
        check("err", 32'(a_err), 32'(m_err[0]));
        check("err_edge", 32'(b_err), 32'(m_err[1]));
        check("color", {8'd0, a_col_R, a_col_G, a_col_B}, 32'(m_color[0]));
        check("color_edge", {8'd0, b_col_R, b_col_G, b_col_B}, 32'(m_color[1]));
        check("cube_x", 32'(a_cx), 32'(cen_x(0, m_cur)));
        check("cube_x_edge", 32'(b_cx), 32'(cen_x(1, m_cur)));
        check("cube_y", 32'(a_cy), 32'(cen_y(m_cur)));
        start = 1'b0; frame_start = 1'b0; pix_valid = 1'b0;
    endtask

    // Stream a 20x20 patch around each instance's active window, clipped to 640x480.
    task automatic stream(input int mode);
        int cx, cy;
        bit pv, st;
        for (int d = 0; d < 2; d++) begin
            cx = cen_x(d, m_cur);
            cy = cen_y(m_cur);
            for (int y = cy - 10; y < cy + 10; y++) begin
                for (int x = cx - 10; x < cx + 10; x++) begin
                    if (x >= 0 && x < 640 && y >= 0 && y < 480) begin
                        pv = (mode == MODE_RAND) ? ($urandom_range(0, 39) != 0) : 1'b1;
                        st = (mode == MODE_START) && (x == cx) && (y == cy);
                        drive(st, 1'b0, pv, x, y, pix_col(mode, x));
                    end
                end
            end
        end
    endtask

    // Frame boundary; some modes put a valid pixel inside the window on it.
    task automatic boundary(input int mode);
        bit pv;
        logic [23:0] c;
        pv = (mode == MODE_EDGE) ? 1'b1 : 1'($urandom_range(0, 1));
        c  = (mode == MODE_EDGE) ? 24'hFFFFFF : 24'($urandom);
        drive(1'b0, 1'b1, pv, cen_x(0, m_cur), cen_y(m_cur), c);
    endtask

    task automatic check_store();
        for (int i = 0; i < 11; i++) begin
            rd_idx = (i < 9) ? 4'(i) : ((i == 9) ? 4'd9 : 4'd15);
            #1;
            check("rd", {8'd0, a_rd_R, a_rd_G, a_rd_B}, (i < 9) ? 32'(m_store[0][i]) : 32'd0);
            check("rd_edge", {8'd0, b_rd_R, b_rd_G, b_rd_B}, (i < 9) ? 32'(m_store[1][i]) : 32'd0);
        end
    endtask

    task automatic check_reset_state();
        check("rst_busy", {30'd0, a_busy, b_busy}, 32'd0);
        check("rst_done", {30'd0, a_done, b_done}, 32'd0);
        check("rst_err", {30'd0, a_err, b_err}, 32'd0);
        check("rst_cur", {24'd0, a_cur, b_cur}, 32'd0);
        check("rst_color", {8'd0, a_col_R, a_col_G, a_col_B}, 32'd0);
        check("rst_color_edge", {8'd0, b_col_R, b_col_G, b_col_B}, 32'd0);
        check("rst_cube_x", {12'd0, a_cx, b_cx}, {12'd0, 10'd280, 10'd630});
        check("rst_cube_y", 32'(a_cy), 32'd200);
        check("cube_s", {12'd0, a_cs, b_cs}, {12'd0, 10'd8, 10'd8});
    endtask

    task automatic mid_reset();
        Reset = 1'b1;
        #2;
        model_reset();
        check_reset_state();
        check_store();
        @(posedge Clk); #1;
        Reset = 1'b0;
    endtask

    // One scan: optional start, an arm frame of ignored pixels, then 10 frame
    // boundaries. reset_after>0 asserts Reset right after that boundary.
    task automatic run_scan(input int mode, input bit do_start, input int reset_after);
        int done_before;
        done_before = n_done;
        if (do_start) drive(1'b1, 1'b0, 1'b0, 0, 0, 24'h0);
        drive(1'b0, 1'b0, 1'b0, 0, 0, 24'h0);
        stream(mode);
        for (int f = 1; f <= 10; f++) begin
            boundary(mode);
            if (f == reset_after) begin
                mid_reset();
                return;
            end
            if (f < 10) begin
                stream(mode);
                drive(1'b0, 1'b0, 1'b0, 0, 0, 24'h0);
            end
        end
        if (mode == MODE_START) begin
            // start in the same cycle that done is high must be accepted
            drive(1'b1, 1'b0, 1'b0, 0, 0, 24'h0);
        end else begin
            drive(1'b0, 1'b0, 1'b0, 0, 0, 24'h0);
        end
        check("done_pulses", 32'(n_done - done_before), 32'd1);
        check_store();
    endtask

    initial begin
        Reset = 1'b1; start = 1'b0; frame_start = 1'b0; pix_valid = 1'b0;
        DrawX = 10'd0; DrawY = 10'd0; pix_R = 8'd0; pix_G = 8'd0; pix_B = 8'd0;
        rd_idx = 4'd0;
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        check_reset_state();
        check_store();
        Reset = 1'b0;

        // constant colour: every entry 40/80/C0, full windows; edge grid short
        run_scan(MODE_CONST, 1'b1, 0);
        rd_idx = 4'd4; #1;
        check("const_entry4", {8'd0, a_rd_R, a_rd_G, a_rd_B}, 32'h004080C0);
        check("const_err", 32'(a_err), 32'd0);
        check("edge_err", 32'(b_err), 32'd1);

        // alternating 00/FF columns: 32640 >> 8 truncates to 7F
        run_scan(MODE_ALT, 1'b1, 0);
        rd_idx = 4'd4; #1;
        check("alt_entry4", {8'd0, a_rd_R, a_rd_G, a_rd_B}, 32'h007F7F7F);

        // random colours with dropped pixels
        run_scan(MODE_RAND, 1'b1, 0);

        // reset after the 5th frame_start, then a fresh complete scan
        run_scan(MODE_RAND, 1'b1, 5);
        run_scan(MODE_RAND, 1'b1, 0);

        // start pulses while busy are ignored; start on done chains a scan
        run_scan(MODE_START, 1'b1, 0);
        run_scan(MODE_RAND, 1'b0, 0);

        // bright pixel on every frame boundary must not leak into averages
        run_scan(MODE_EDGE, 1'b1, 0);
        rd_idx = 4'd0; #1;
        check("edge_entry0", {8'd0, a_rd_R, a_rd_G, a_rd_B}, 32'h00102030);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
